stopwatch_control: RTL and testbench

Button front-end and run-control FSM for the stopwatch. It sits directly upstream of the ms/sec counter and 7-segment decode stage. It takes the two raw board pushbuttons and synchronises and debounces them. It then drives the counter's `enable` (via `run`), a synchronous clear request, and a display-freeze (lap) signal that is consumed by the display path.

---
 rtl/stopwatch_control_if.sv | 35 +++
 rtl/stopwatch_control.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_control.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_control_if
//  Description : Button inputs and run-control outputs of the stopwatch
//                front-end, bundled for connection to stopwatch_control.
//                master = board/test side, slave = stopwatch_control side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_control_if;
    logic       btn_start_n;
    logic       btn_lap_n;
    logic       run;
    logic       clear;
    logic       freeze;
    logic [1:0] state;

    modport master (
        output btn_start_n,
        output btn_lap_n,
        input  run,
        input  clear,
        input  freeze,
        input  state
    );

    modport slave (
        input  btn_start_n,
        input  btn_lap_n,
        output run,
        output clear,
        output freeze,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_control.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_control
//  Description : Synchronises and debounces the start/stop and lap/reset
//                pushbuttons, turns debounced presses into single-cycle
//                events and runs the IDLE/RUNNING/LAP/PAUSED control FSM
//                driving the counter enable, clear pulse and display freeze.
//                Optional feature macro: STOPWATCH_LAP_EN (builds the LAP
//                state and the freeze output; otherwise freeze is tied low).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_control_if.slave  bus
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 = start/stop button, index 1 = lap/reset button.
    logic [1:0] raw_n;
    logic [1:0] press;

    assign raw_n = {bus.btn_lap_n, bus.btn_start_n};

    // ------------------------------------------------------------------
    // Per-button front-end: 2-flop synchroniser, debouncer, press event.
    // Levels are kept active-low throughout: 1 = released, 0 = pressed.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             db_q, db_d;
        logic             db_dly_q, db_dly_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_q, press_d;

        // Debounce counter: restart on any return to the accepted level,
        // accept the new level after DEBOUNCE_CYCLES consecutive differing samples.
        always_comb begin
            sync1_d  = raw_n[i];
            sync2_d  = sync1_q;
            db_d     = db_q;
            cnt_d    = '0;
            db_dly_d = db_q;
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Released -> pressed transition of the accepted level only.
            press_d = db_dly_q & ~db_q;
        end

        // Front-end registers; everything restarts in the released condition.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q  <= 1'b1;
                sync2_q  <= 1'b1;
                db_q     <= 1'b1;
                db_dly_q <= 1'b1;
                cnt_q    <= '0;
                press_q  <= 1'b0;
            end else begin
                sync1_q  <= sync1_d;
                sync2_q  <= sync2_d;
                db_q     <= db_d;
                db_dly_q <= db_dly_d;
                cnt_q    <= cnt_d;
                press_q  <= press_d;
            end
        end

        assign press[i] = press_q;
    end

    logic p_start;
    logic p_lap;

    assign p_start = press[0];
    assign p_lap   = press[1];

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        LAP     = 2'b10,
        PAUSED  = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   run_q, run_d;
    logic   clear_q, clear_d;
`ifdef STOPWATCH_LAP_EN
    logic   freeze_q, freeze_d;
`endif

    // Next state and next outputs; start always takes priority over lap.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_start) begin
                    state_d = RUNNING;
                end else if (p_lap) begin
                    clear_d = 1'b1;
                end
            end
            RUNNING: begin
                if (p_start) begin
                    state_d = PAUSED;
                end
`ifdef STOPWATCH_LAP_EN
                else if (p_lap) begin
                    state_d = LAP;
                end
`endif
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (p_start) begin
                    state_d = PAUSED;
                end else if (p_lap) begin
                    state_d = RUNNING;
                end
            end
`endif
            PAUSED: begin
                if (p_start) begin
                    state_d = RUNNING;
                end else if (p_lap) begin
                    clear_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef STOPWATCH_LAP_EN
        run_d    = (state_d == RUNNING) || (state_d == LAP);
        freeze_d = (state_d == LAP);
`else
        run_d    = (state_d == RUNNING);
`endif
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            clear_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            freeze_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            clear_q  <= clear_d;
`ifdef STOPWATCH_LAP_EN
            freeze_q <= freeze_d;
`endif
        end
    end

    assign bus.run   = run_q;
    assign bus.clear = clear_q;
    assign bus.state = state_q;
`ifdef STOPWATCH_LAP_EN
    assign bus.freeze = freeze_q;
`else
    assign bus.freeze = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_control
//  Description : Self-checking bench for stopwatch_control (DEBOUNCE_CYCLES=4).
//                A behavioural model tracks every cycle; a vector table and
//                hand sequences add fixed expectations; random button
//                activity exercises the rest.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_control;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_s = 1'b1;
    logic raw_l = 1'b1;

    int total = 0;
    int bad   = 0;

    stopwatch_control_if sw_if();
    assign sw_if.btn_start_n = raw_s;
    assign sw_if.btn_lap_n   = raw_l;

    stopwatch_control #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. States: 0 idle, 1 running, 2 lap, 3 paused.
    // ------------------------------------------------------------------
    bit raw_hist[2][$];   // pin samples of recent edges
    bit syn_hist[2][$];   // last D levels seen by the debouncer
    bit ev_hist[2][$];    // press events of recent edges
    bit m_db[2];
    int ms;
    bit e_clear;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    task automatic mreset();
        for (int b = 0; b < 2; b++) begin
            raw_hist[b].delete();
            syn_hist[b].delete();
            ev_hist[b].delete();
            repeat (3) raw_hist[b].push_back(1'b1);
            repeat (D) syn_hist[b].push_back(1'b1);
            repeat (3) ev_hist[b].push_back(1'b0);
            m_db[b] = 1'b1;
        end
        ms      = 0;
        e_clear = 1'b0;
    endtask

    task automatic model_edge();
        bit ev_now[2];
        bit cur;
        bit all_diff;
        if (rst) begin
            mreset();
            return;
        end
        for (int b = 0; b < 2; b++) begin
            cur = (b == 0) ? raw_s : raw_l;
            raw_hist[b].push_back(cur);
            // the debouncer sees the pin as it was two edges ago
            syn_hist[b].push_back(raw_hist[b][raw_hist[b].size() - 3]);
            void'(raw_hist[b].pop_front());
            void'(syn_hist[b].pop_front());
            all_diff = 1'b1;
            foreach (syn_hist[b][k]) if (syn_hist[b][k] == m_db[b]) all_diff = 1'b0;
            ev_hist[b].push_back(all_diff && m_db[b]);
            if (all_diff) m_db[b] = ~m_db[b];
            // an accepted press acts on the outputs two edges later
            ev_now[b] = ev_hist[b][ev_hist[b].size() - 3];
            void'(ev_hist[b].pop_front());
        end
        e_clear = 1'b0;
        case (ms)
            0: if (ev_now[0]) ms = 1; else if (ev_now[1]) e_clear = 1'b1;
            1: if (ev_now[0]) ms = 3; else if (ev_now[1] && LAP_EN) ms = 2;
            2: if (ev_now[0]) ms = 3; else if (ev_now[1]) ms = 1;
            default: if (ev_now[0]) ms = 1; else if (ev_now[1]) begin ms = 0; e_clear = 1'b1; end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge, update the model, compare just after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("run",    int'(sw_if.run),    int'(ms == 1 || ms == 2));
        chk("freeze", int'(sw_if.freeze), int'(ms == 2));
        chk("clear",  int'(sw_if.clear),  int'(e_clear));
        chk("state",  int'(sw_if.state),  ms);
    endtask

    task automatic hold(input bit s_n, input bit l_n, input int n);
        raw_s = s_n;
        raw_l = l_n;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit       s_n;
        bit       l_n;
        int       cyc;
        int       st;
        bit       run;
        bit       frz;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int clr_cnt;
        int hs, hl;

        // {start_n, lap_n, cycles, state, run, freeze} after the phase
        tbl.push_back('{1, 1, 20, 0, 0, 0});
        tbl.push_back('{0, 1, 12, 1, 1, 0});
        tbl.push_back('{1, 1, 12, 1, 1, 0});
        tbl.push_back('{1, 0, 12, LAP_EN ? 2 : 1, 1, LAP_EN});
        tbl.push_back('{1, 1, 12, LAP_EN ? 2 : 1, 1, LAP_EN});
        tbl.push_back('{1, 0, 12, 1, 1, 0});
        tbl.push_back('{1, 1, 12, 1, 1, 0});
        tbl.push_back('{0, 1, 12, 3, 0, 0});
        tbl.push_back('{1, 1, 12, 3, 0, 0});
        tbl.push_back('{1, 0, 12, 0, 0, 0});
        tbl.push_back('{1, 1, 12, 0, 0, 0});
        tbl.push_back('{0, 1, 12, 1, 1, 0});
        tbl.push_back('{1, 1, 12, 1, 1, 0});
        tbl.push_back('{0, 1, 12, 3, 0, 0});
        tbl.push_back('{1, 1, 12, 3, 0, 0});
        tbl.push_back('{0, 0, 12, 1, 1, 0});
        tbl.push_back('{1, 1, 12, 1, 1, 0});

        mreset();
        do_reset();

        foreach (tbl[i]) begin
            hold(tbl[i].s_n, tbl[i].l_n, tbl[i].cyc);
            chk("tbl_state",  int'(sw_if.state),  tbl[i].st);
            chk("tbl_run",    int'(sw_if.run),    int'(tbl[i].run));
            chk("tbl_freeze", int'(sw_if.freeze), int'(tbl[i].frz));
            chk("tbl_clear",  int'(sw_if.clear),  0);
        end

        // Exact press latency: the pin goes low just after edge 0,
        // outputs change at edge 4+D = 8.
        do_reset();
        hold(1, 1, 4);
        hold(0, 1, 7);
        chk("lat_run_e7", int'(sw_if.run), 0);
        tick();
        chk("lat_run_e8",   int'(sw_if.run),   1);
        chk("lat_state_e8", int'(sw_if.state), 1);
        hold(0, 1, 10);
        chk("held_state", int'(sw_if.state), 1);
        hold(1, 1, 10);
        hold(0, 1, 10);
        chk("repress_state", int'(sw_if.state), 3);
        chk("repress_run",   int'(sw_if.run),   0);
        hold(1, 1, 10);

        // Bounce shorter than the debounce window never registers.
        do_reset();
        repeat (5) begin
            hold(0, 1, 3);
            hold(1, 1, 1);
        end
        hold(1, 1, 8);
        chk("bounce_state", int'(sw_if.state), 0);
        hold(0, 1, 10);
        hold(0, 1, 10);
        chk("one_event_state", int'(sw_if.state), 1);
        hold(1, 1, 10);

        // Clear from PAUSED lasts exactly one cycle.
        hold(0, 1, 10);
        hold(1, 1, 10);
        raw_l   = 1'b0;
        clr_cnt = 0;
        repeat (12) begin
            tick();
            if (sw_if.clear) clr_cnt++;
        end
        chk("clear_len",   clr_cnt, 1);
        chk("clear_state", int'(sw_if.state), 0);
        hold(1, 1, 10);

        // Reset mid-debounce with start held.
        hold(0, 1, 10);
        hold(1, 1, 10);
        raw_s = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("async_run",   int'(sw_if.run),   0);
        chk("async_state", int'(sw_if.state), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_early", int'(sw_if.state), 0);
        repeat (9) tick();
        chk("post_rst_event", int'(sw_if.state), 1);
        hold(1, 1, 10);

        // Random button activity against the model.
        hs = 0;
        hl = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hs == 0) begin
                raw_s = $urandom_range(0, 1);
                hs    = $urandom_range(1, 12);
            end
            if (hl == 0) begin
                raw_l = $urandom_range(0, 1);
                hl    = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            else rst = 1'b0;
            tick();
            hs--;
            hl--;
        end
        rst = 1'b0;
        hold(1, 1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
